conv_out_serializer: RTL
========================

Name: conv_out_serializer

Overview:
- Sits on the conv engine master side and consumes the wide conv output stream (cmgu-packed, COPIES*MEMBERS*GROUPS*UNITS*WORD_WIDTH_ACC bits, plus tuser and tlast).
- Re-emits each wide beat as BEATS narrower M_DATA_WIDTH beats, least-significant slice first, toward the output DMA.
- Buffering is two-entry ping-pong, so a new conv beat can land while the previous one drains. This gives full throughput.

Parameters:
- UNITS, 4, units per core
- GROUPS, 1, groups per copy
- COPIES, 2, copies
- MEMBERS, 2, members per group
- WORD_WIDTH_ACC, 32, accumulator word width
- M_DATA_WIDTH, 128, output beat width. S_DATA_WIDTH must be an integer multiple of it.
- TUSER_WIDTH, 8, tuser width (TUSER_WIDTH_LRELU_IN)
- Derived: S_DATA_WIDTH = COPIES*MEMBERS*GROUPS*UNITS*WORD_WIDTH_ACC (512 by default)
- Derived: BEATS = S_DATA_WIDTH/M_DATA_WIDTH (4 by default)
- Derived: BITS_BEATS = max(1, clog2(BEATS))

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous, active-high reset
- s_axis_tready  out  1  conv-side ready
- s_axis_tvalid  in  1  conv-side valid
- s_axis_tlast  in  1  last conv beat of packet
- s_axis_tuser  in  TUSER_WIDTH  per-beat sideband
- s_axis_tdata  in  S_DATA_WIDTH  cmgu-packed accumulator words
- m_axis_tready  in  1  downstream ready
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last narrow beat of packet
- m_axis_tuser  out  TUSER_WIDTH  copy of the stored entry's tuser
- m_axis_tdata  out  M_DATA_WIDTH  current slice

Behaviour:
- Clocking and reset: one clock, aclk; reset areset is synchronous and active-high.
- State:
  - buf[0:1], each holding data, tuser and tlast
  - wr_ptr, rd_ptr (1 bit each)
  - count (0..2)
  - sub (0..BEATS-1)
- Reset (areset=1 at a rising edge):
  - count, wr_ptr, rd_ptr and sub all go to 0.
  - Next cycle: s_axis_tready=1, m_axis_tvalid=0, m_axis_tlast=0.
  - m_axis_tdata and m_axis_tuser read 0 while invalid (buffer contents are not reset, so outputs are gated).
  - Reset mid-packet discards all buffered data. No partial beats are emitted afterwards.
- Handshakes and outputs:
  - s_axis_tready = (count != 2). It is registered-state only, with no combinational path from m_axis_tready.
  - Push: s_axis_tvalid & s_axis_tready. Writes buf[wr_ptr] and toggles wr_ptr.
  - m_axis_tvalid = (count != 0).
  - m_axis_tdata = buf[rd_ptr].data[sub*M_DATA_WIDTH +: M_DATA_WIDTH].
  - m_axis_tuser = buf[rd_ptr].tuser on every sub-beat.
  - m_axis_tlast = buf[rd_ptr].tlast & (sub == BEATS-1).
- Sub-beat advance: on m_axis_tvalid & m_axis_tready, sub increments.
  - When sub == BEATS-1 it wraps to 0: pop, rd_ptr toggles.
  - BEATS=1: sub is held at 0 and every output handshake is a pop.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged. This is legal only when count==1, because push is blocked at count==2.
- Latency: first narrow beat is valid the cycle after the accepting edge, when the buffer was empty.
- Throughput:
  - Sustained 1 narrow beat per cycle with m_axis_tready held at 1.
  - BEATS=1 sustains 1 wide beat per cycle.
- Backpressure: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tuser, m_axis_tlast and sub are held stable (AXIS rule).
- Full: with count==2, s_axis_tready=0. It rises the cycle after the pop completes.
- Empty: with count==0, m_axis_tvalid=0 and sub stays 0.
- tvalid from the conv side may be asserted without waiting for tready. Data is captured only on handshake.
- Slice order is LSB first. This matches the packing used by the input splitter, so word (c,m,g,u) keeps the same bit position end-to-end.

Test Plan:
1. Reset, then one beat with data = {16 words 0x0F..0x00} (word i = i), tuser=0x5A, tlast=1, m_axis_tready=1.
   Required: 4 beats, valid from the cycle after the accept.
   Beat 0 = words 3..0, beat 3 = words 15..12.
   tuser=0x5A on all 4 beats; tlast only on beat 3.
2. Back-to-back: 3 conv beats offered continuously, m_axis_tready=1.
   Required: 12 contiguous output beats, no bubbles. s_axis_tready drops to 0 at count==2 and recovers.
3. Backpressure: m_axis_tready toggles 1,0,0,1 during a packet.
   Required: outputs stable during the low cycles; no beat duplicated or dropped (12 beats, in order).
4. Full buffer: m_axis_tready=0, offer 3 beats.
   Required: exactly 2 accepted; third s_axis_tready=0 until the first pop completes (4 output handshakes later).
5. Reset mid-packet: assert areset after output beat 1 of 4.
   Required: next cycle m_axis_tvalid=0, s_axis_tready=1; a new beat then emits starting at its slice 0.
6. BEATS=1 build (M_DATA_WIDTH=512): stream 5 beats with tlast on the 5th.
   Required: 5 output beats, one per cycle; tlast on the 5th only.

Source files
------------

// File: rtl/conv_out_serializer.sv
// rtl/conv_out_serializer.sv - wide conv output beat to narrow output beat serializer
//
// Takes one cmgu-packed conv output beat (S_DATA_WIDTH bits) and re-emits it
// as BEATS beats of M_DATA_WIDTH bits, least-significant slice first. A
// two-entry ping-pong buffer lets the next wide beat land while the current
// one drains, so a full-rate narrow stream is sustained.
//
// Ports:
//   aclk           clock
//   areset         synchronous, active-high reset
//   s_axis_tready  conv side ready (depends on buffer occupancy only)
//   s_axis_tvalid  conv side valid
//   s_axis_tlast   last conv beat of packet
//   s_axis_tuser   per-beat sideband
//   s_axis_tdata   cmgu-packed accumulator words
//   m_axis_tready  downstream ready
//   m_axis_tvalid  output valid
//   m_axis_tlast   last narrow beat of packet
//   m_axis_tuser   sideband of the entry being drained
//   m_axis_tdata   current slice

module conv_out_serializer #(
   parameter int UNITS          = 4,
   parameter int GROUPS         = 1,
   parameter int COPIES         = 2,
   parameter int MEMBERS        = 2,
   parameter int WORD_WIDTH_ACC = 32,
   parameter int M_DATA_WIDTH   = 128,
   parameter int TUSER_WIDTH    = 8,
   localparam int S_DATA_WIDTH  = COPIES * MEMBERS * GROUPS * UNITS * WORD_WIDTH_ACC,
   localparam int BEATS         = S_DATA_WIDTH / M_DATA_WIDTH,
   localparam int BITS_BEATS    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                    aclk,
   input  logic                    areset,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   input  logic [TUSER_WIDTH-1:0]  s_axis_tuser,
   input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   output logic [TUSER_WIDTH-1:0]  m_axis_tuser,
   output logic [M_DATA_WIDTH-1:0] m_axis_tdata
);

   logic [S_DATA_WIDTH-1:0] buf_data [2];
   logic [TUSER_WIDTH-1:0]  buf_user [2];
   logic                    buf_last [2];

   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            count;
   logic [BITS_BEATS-1:0] sub;

   logic push;
   logic out_hs;
   logic last_sub;
   logic pop;

   // Ready comes from occupancy alone, so there is no combinational path
   // from m_axis_tready back to the conv engine.
   assign s_axis_tready = (count != 2'd2);
   assign m_axis_tvalid = (count != 2'd0);

   assign push     = s_axis_tvalid & s_axis_tready;
   assign out_hs   = m_axis_tvalid & m_axis_tready;
   // With BEATS=1 the compare value is 0 and sub never leaves 0, so every
   // output handshake is a pop.
   assign last_sub = (sub == BITS_BEATS'(BEATS - 1));
   assign pop      = out_hs & last_sub;

   // Buffer contents are never reset, so outputs are forced to zero while
   // nothing valid is held.
   assign m_axis_tdata = m_axis_tvalid ? buf_data[rd_ptr][int'(sub) * M_DATA_WIDTH +: M_DATA_WIDTH]
                                       : '0;
   assign m_axis_tuser = m_axis_tvalid ? buf_user[rd_ptr] : '0;
   assign m_axis_tlast = m_axis_tvalid & buf_last[rd_ptr] & last_sub;

   // Storage: written only on an accepted conv beat.
   always_ff @(posedge aclk) begin
      if (push) begin
         buf_data[wr_ptr] <= s_axis_tdata;
         buf_user[wr_ptr] <= s_axis_tuser;
         buf_last[wr_ptr] <= s_axis_tlast;
      end
   end

   // Control state: pointers, occupancy and slice index.
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         sub    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end

         // sub only moves on an output handshake, which keeps the slice
         // stable under backpressure.
         if (out_hs) begin
            if (last_sub) begin
               sub    <= '0;
               rd_ptr <= ~rd_ptr;
            end else begin
               sub <= sub + BITS_BEATS'(1);
            end
         end

         // Push and pop together only happens at count==1 (push is blocked
         // at count==2), so the count simply holds.
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule
